// File: rtl/alu_check_pkg.sv
// Shared definitions for the ALU result checker: operation encodings,
// checker FSM states and the layout of a captured failing vector.
package alu_check_pkg;

    localparam int SEL_W      = 2;
    localparam int OPND_W     = 4;
    localparam int FAIL_VEC_W = SEL_W + 3 * OPND_W + 1;

    localparam logic [SEL_W-1:0] OP_ADD = 2'b00;
    localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
    localparam logic [SEL_W-1:0] OP_MUL = 2'b10;
    localparam logic [SEL_W-1:0] OP_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Field order matches the fail_vec port: {sel, a, b, q, ov}
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] q;
        logic              ov;
    } fail_vec_t;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference for the 4-bit signed arithmetic unit; results are
// formed at 8-bit signed precision, then truncated and range-checked.
module alu_golden_model
    import alu_check_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [OPND_W-1:0] exp_q,
    output logic              exp_ov
);

    logic signed [7:0] ax;
    logic signed [7:0] bx;
    logic signed [7:0] res;

    // 8 bits holds every result exactly (worst case -8 * -8 = 64)
    always_comb begin
        ax  = {{4{a[3]}}, a};
        bx  = {{4{b[3]}}, b};
        res = '0;
        case (sel)
            OP_ADD:  res = ax + bx;
            OP_SUB:  res = ax - bx;
            OP_MUL:  res = ax * bx;
            OP_NEG:  res = -ax;
            default: res = '0;
        endcase
        exp_q  = res[3:0];
        exp_ov = (res > 8'sd7) || (res < -8'sd8);
    end

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage response checker for the 4-bit signed arithmetic unit.
// Define ALU_CHECK_HALT_ON_FAIL_EN to end the run at the first mismatch.
module alu_result_checker
    import alu_check_pkg::*;
#(
    parameter int NUM_VECTORS = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      sel,
    input  logic [OPND_W-1:0]     a,
    input  logic [OPND_W-1:0]     b,
    input  logic [OPND_W-1:0]     q,
    input  logic                  ov,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      vec_count,
    output logic [CNT_W-1:0]      err_count,
    output logic                  mismatch,
    output logic                  fail_valid,
    output logic [FAIL_VEC_W-1:0] fail_vec
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_VECTORS);

    state_t            state;
    state_t            next_state;
    logic              s1_valid;
    fail_vec_t         s1_vec;
    fail_vec_t         fail_q;
    logic [OPND_W-1:0] exp_q;
    logic              exp_ov;
    logic              upd;
    logic              bad;
    logic              last_vec;
    logic              halt_hit;
    logic              end_run;
    logic [CNT_W-1:0]  vec_next;

    alu_golden_model u_golden (
        .sel    (s1_vec.sel),
        .a      (s1_vec.a),
        .b      (s1_vec.b),
        .exp_q  (exp_q),
        .exp_ov (exp_ov)
    );

    // A restart discards whatever vector is sitting in stage 1
    assign upd      = (state == RUN) && s1_valid && !start;
    assign bad      = (s1_vec.q != exp_q) || (s1_vec.ov != exp_ov);
    assign vec_next = vec_count + 1'b1;
    assign last_vec = upd && (vec_next == LAST_COUNT);

`ifdef ALU_CHECK_HALT_ON_FAIL_EN
    assign halt_hit = upd && bad;
`else
    assign halt_hit = 1'b0;
`endif

    assign end_run  = last_vec || halt_hit;
    assign fail_vec = fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (start) begin
                    next_state = RUN;
                end else if (end_run) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage 1: a vector entering on the cycle the run ends is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
        end else begin
            s1_valid <= in_valid && !start && (state == RUN) && (next_state == RUN);
            if (in_valid) begin
                s1_vec <= {sel, a, b, q, ov};
            end
        end
    end

    // Stage 2: compare against the golden model and update the run record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count  <= '0;
            err_count  <= '0;
            mismatch   <= 1'b0;
            fail_valid <= 1'b0;
            fail_q     <= '0;
            pass       <= 1'b0;
        end else if (start) begin
            vec_count  <= '0;
            err_count  <= '0;
            mismatch   <= 1'b0;
            fail_valid <= 1'b0;
            fail_q     <= '0;
            pass       <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (upd) begin
                vec_count <= vec_next;
                if (bad) begin
                    mismatch <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_q     <= s1_vec;
                    end
                end
                if (end_run) begin
                    pass <= (err_count == '0) && !bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker: shuffled full sweeps with random
// gaps and fault injection, scored against an integer-arithmetic reference.
module tb_alu_result_checker;

    localparam int NUM_VECTORS = 1024;
    localparam int CNT_W       = 16;
`ifdef ALU_CHECK_HALT_ON_FAIL_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [1:0]        sel;
    logic [3:0]        a;
    logic [3:0]        b;
    logic [3:0]        q;
    logic              ov;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  vec_count;
    logic [CNT_W-1:0]  err_count;
    logic              mismatch;
    logic              fail_valid;
    logic [14:0]       fail_vec;

    alu_result_checker #(
        .NUM_VECTORS (NUM_VECTORS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .sel        (sel),
        .a          (a),
        .b          (b),
        .q          (q),
        .ov         (ov),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .vec_count  (vec_count),
        .err_count  (err_count),
        .mismatch   (mismatch),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;

    // Scoreboard of the current run
    int          exp_vec;
    int          exp_err;
    bit          exp_first_v;
    logic [14:0] exp_first;
    bit          ended;
    bit          pend_v [2];
    bit          pend_b [2];
    logic [14:0] pend_vec [2];
    int          order [NUM_VECTORS];

    function automatic void ref_alu(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y,
                                    output logic [3:0] rq, output logic rov);
        int sx;
        int sy;
        int r;
        sx = int'(x);
        sy = int'(y);
        if (sx > 7) sx -= 16;
        if (sy > 7) sy -= 16;
        case (s)
            2'd0:    r = sx + sy;
            2'd1:    r = sx - sy;
            2'd2:    r = sx * sy;
            default: r = -sx;
        endcase
        rq  = 4'(r);
        rov = (r < -8) || (r > 7);
    endfunction

    task automatic sb_clear();
        exp_vec     = 0;
        exp_err     = 0;
        exp_first_v = 1'b0;
        exp_first   = '0;
        ended       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend_v[i]   = 1'b0;
            pend_b[i]   = 1'b0;
            pend_vec[i] = '0;
        end
    endtask

    // One cycle: retire the vector driven two cycles ago, check, drive a new one
    task automatic apply_stimulus(input bit v, input logic [1:0] s, input logic [3:0] x,
                                  input logic [3:0] y, input logic [3:0] uq, input logic uov);
        bit         exp_mm;
        logic [3:0] gq;
        logic       gov;
        @(negedge clk);
        exp_mm = 1'b0;
        if (pend_v[1]) begin
            exp_vec++;
            if (pend_b[1]) begin
                exp_err++;
                exp_mm = 1'b1;
                if (!exp_first_v) begin
                    exp_first_v = 1'b1;
                    exp_first   = pend_vec[1];
                end
            end
            if (exp_vec == NUM_VECTORS || (HALT && pend_b[1])) begin
                ended     = 1'b1;
                pend_v[0] = 1'b0;
            end
        end
        n_cmp++;
        if (vec_count !== CNT_W'(exp_vec)) begin
            n_bad++;
            $display("[TB] FAIL cyc_vec_count: got %0d expected %0d", vec_count, exp_vec);
        end
        n_cmp++;
        if (err_count !== CNT_W'(exp_err)) begin
            n_bad++;
            $display("[TB] FAIL cyc_err_count: got %0d expected %0d", err_count, exp_err);
        end
        n_cmp++;
        if (mismatch !== exp_mm) begin
            n_bad++;
            $display("[TB] FAIL cyc_mismatch: got %b expected %b (vec %0d)", mismatch, exp_mm, exp_vec);
        end
        n_cmp++;
        if ({busy, done} !== {!ended, ended}) begin
            n_bad++;
            $display("[TB] FAIL cyc_busy_done: got %b%b expected %b%b", busy, done, !ended, ended);
        end
        ref_alu(s, x, y, gq, gov);
        pend_v[1]   = pend_v[0];
        pend_b[1]   = pend_b[0];
        pend_vec[1] = pend_vec[0];
        pend_v[0]   = v && !ended;
        pend_b[0]   = (uq != gq) || (uov != gov);
        pend_vec[0] = {s, x, y, uq, uov};
        in_valid = v;
        sel      = s;
        a        = x;
        b        = y;
        q        = uq;
        ov       = uov;
    endtask

    task automatic start_run();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'($urandom);
        a        = 4'($urandom);
        b        = 4'($urandom);
        q        = 4'($urandom);
        ov       = 1'($urandom);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({vec_count, err_count, fail_valid, fail_vec, done, pass, busy} !== {32'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL start_clear: vec=%0d err=%0d fv=%b fvec=%h done=%b pass=%b busy=%b expected 0,0,0,0,0,0,1",
                     vec_count, err_count, fail_valid, fail_vec, done, pass, busy);
        end
        sb_clear();
    endtask

    // mode 0 correct unit, 1 single injected fault at 7+1, 2 ov stuck at 0,
    // 3 random faults, 4 fault on the fifth vector driven
    task automatic run_sweep(input int mode, input int n_vec);
        logic [9:0] v10;
        logic [3:0] uq;
        logic       uov;
        int         j;
        int         tmp;
        start_run();
        for (int i = 0; i < NUM_VECTORS; i++) order[i] = i;
        for (int i = NUM_VECTORS - 1; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < n_vec; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                apply_stimulus(1'b0, 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            end
            v10 = 10'(order[i]);
            ref_alu(v10[1:0], v10[5:2], v10[9:6], uq, uov);
            case (mode)
                1: if (v10 == {4'd1, 4'd7, 2'd0}) begin uq = 4'd0; uov = 1'b0; end
                2: uov = 1'b0;
                3: if ($urandom_range(15, 0) == 0) uq = uq ^ 4'($urandom_range(15, 1));
                4: if (i == 4) uq = ~uq;
                default: ;
            endcase
            apply_stimulus(1'b1, v10[1:0], v10[5:2], v10[9:6], uq, uov);
        end
        if (n_vec == NUM_VECTORS) begin
            for (int k = 0; k < 3; k++) begin
                apply_stimulus(1'b1, 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            end
            apply_stimulus(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
            n_cmp++;
            if ({done, busy} !== 2'b10) begin
                n_bad++;
                $display("[TB] FAIL end_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
            end
            n_cmp++;
            if (pass !== (exp_err == 0)) begin
                n_bad++;
                $display("[TB] FAIL end_pass: got %b expected %b", pass, exp_err == 0);
            end
            n_cmp++;
            if (fail_valid !== exp_first_v) begin
                n_bad++;
                $display("[TB] FAIL end_fail_valid: got %b expected %b", fail_valid, exp_first_v);
            end
            n_cmp++;
            if (fail_vec !== exp_first) begin
                n_bad++;
                $display("[TB] FAIL end_fail_vec: got %h expected %h", fail_vec, exp_first);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        sel      = '0;
        a        = '0;
        b        = '0;
        q        = '0;
        ov       = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, pass, vec_count, err_count, mismatch, fail_valid, fail_vec} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b pass=%b vec=%0d err=%0d expected all 0",
                     busy, done, pass, vec_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sel      = 2'($urandom);
            a        = 4'($urandom);
            b        = 4'($urandom);
            q        = 4'($urandom);
            ov       = 1'($urandom);
            n_cmp++;
            if ({busy, vec_count, err_count, mismatch} !== '0) begin
                n_bad++;
                $display("[TB] FAIL idle_ignore: got busy=%b vec=%0d err=%0d mm=%b expected 0",
                         busy, vec_count, err_count, mismatch);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clean_sweep();
        run_sweep(0, NUM_VECTORS);
        n_cmp++;
        if ({vec_count, err_count, pass} !== {CNT_W'(NUM_VECTORS), CNT_W'(0), 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL clean_totals: got vec=%0d err=%0d pass=%b expected 1024 0 1",
                     vec_count, err_count, pass);
        end
    endtask

    task automatic test_inject_single();
        logic [14:0] want;
        want = 15'b00_0111_0001_0000_0;
        run_sweep(1, NUM_VECTORS);
        n_cmp++;
        if ({err_count, pass, fail_vec} !== {CNT_W'(1), 1'b0, want}) begin
            n_bad++;
            $display("[TB] FAIL inject_single: got err=%0d pass=%b fvec=%h expected 1 0 %h",
                     err_count, pass, fail_vec, want);
        end
    endtask

    task automatic test_ov_stuck();
        int         ov_total;
        logic [9:0] v10;
        logic [3:0] rq;
        logic       rov;
        ov_total = 0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            v10 = 10'(i);
            ref_alu(v10[1:0], v10[5:2], v10[9:6], rq, rov);
            if (rov) ov_total++;
        end
        if (HALT) ov_total = 1;
        run_sweep(2, NUM_VECTORS);
        n_cmp++;
        if (err_count !== CNT_W'(ov_total)) begin
            n_bad++;
            $display("[TB] FAIL ov_stuck_count: got %0d expected %0d", err_count, ov_total);
        end
    endtask

    task automatic test_random_errors();
        run_sweep(3, NUM_VECTORS);
    endtask

    task automatic test_restart();
        run_sweep(3, 100);
        run_sweep(0, NUM_VECTORS);
        n_cmp++;
        if ({vec_count, pass} !== {CNT_W'(NUM_VECTORS), 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL restart_fresh: got vec=%0d pass=%b expected 1024 1", vec_count, pass);
        end
    endtask

    task automatic test_async_reset_midrun();
        run_sweep(3, 50);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, pass, vec_count, err_count, mismatch, fail_valid, fail_vec} !== '0) begin
            n_bad++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b vec=%0d err=%0d fv=%b expected all 0",
                     busy, done, vec_count, err_count, fail_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sel      = 2'($urandom);
            a        = 4'($urandom);
            b        = 4'($urandom);
            q        = 4'($urandom);
            ov       = 1'($urandom);
            n_cmp++;
            if ({busy, done, vec_count} !== '0) begin
                n_bad++;
                $display("[TB] FAIL post_reset_idle: got busy=%b done=%b vec=%0d expected 0", busy, done, vec_count);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_halt_on_fail();
        run_sweep(4, NUM_VECTORS);
`ifdef ALU_CHECK_HALT_ON_FAIL_EN
        n_cmp++;
        if ({vec_count, err_count, done, pass} !== {CNT_W'(5), CNT_W'(1), 1'b1, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL halt_at_5: got vec=%0d err=%0d done=%b pass=%b expected 5 1 1 0",
                     vec_count, err_count, done, pass);
        end
`else
        n_cmp++;
        if ({vec_count, err_count, done, pass} !== {CNT_W'(NUM_VECTORS), CNT_W'(1), 1'b1, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL no_halt: got vec=%0d err=%0d done=%b pass=%b expected 1024 1 1 0",
                     vec_count, err_count, done, pass);
        end
`endif
    endtask

    // Tests run in order; each leaves the checker in a state the next restarts from
    initial begin
        n_cmp = 0;
        n_bad = 0;
        sb_clear();
        test_reset();
        test_clean_sweep();
        test_inject_single();
        test_ov_stuck();
        test_random_errors();
        test_restart();
        test_async_reset_midrun();
        test_halt_on_fail();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
